// File: rtl/pmod_led_pattern_gen.sv
// Purpose : animated 32-bit LED pattern (count/walk/bounce/fill/blink) stepping every DIV clocks.
// Latency : a step is visible on pmod/led the cycle after the prescaler terminal count, with step_tick.
// Backpres: none; free-running source, run=0 freezes the prescaler and the pattern.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   mode[2:0]  0 OFF, 1 COUNT, 2 WALK, 3 BOUNCE, 4 FILL, 5 BLINK, 6/7 behave as OFF
//   run        1 = prescaler advances, 0 = hold prescaler and pattern
//   step_tick  one-cycle pulse on the cycle a new pattern value appears
//   pmod[3:0]  pmod[k] = pat[8k+7:8k]
//   led[7:0]   pat[31:24], mirrors pmod[3]
module pmod_led_pattern_gen #(
   parameter int DIV = 25_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      mode,
   input  logic            run,
   output logic            step_tick,
   output logic [3:0][7:0] pmod,
   output logic [7:0]      led
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [2:0] MODE_OFF    = 3'd0;
   localparam logic [2:0] MODE_COUNT  = 3'd1;
   localparam logic [2:0] MODE_WALK   = 3'd2;
   localparam logic [2:0] MODE_BOUNCE = 3'd3;
   localparam logic [2:0] MODE_FILL   = 3'd4;
   localparam logic [2:0] MODE_BLINK  = 3'd5;

   localparam logic [31:0] PAT_TOP = 32'h8000_0000;
   localparam logic [31:0] PAT_BOT = 32'h0000_0001;
   localparam logic [31:0] PAT_ALL = 32'hFFFF_FFFF;

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]    cur_mode_q, cur_mode_d;
   logic [31:0]   pat_q, pat_d;
   logic          dir_q, dir_d;
   logic          step_tick_q, step_tick_d;

   logic          tick;
   logic [31:0]   pat_nxt;
   logic          dir_nxt;

   function automatic logic [31:0] init_pat(input logic [2:0] m);
      logic [31:0] r;
      r = 32'd0;
      if (m == MODE_WALK || m == MODE_BOUNCE) begin
         r = PAT_BOT;
      end
      return r;
   endfunction

   // Prescaler terminal count; gated by run so a frozen prescaler never steps.
   assign tick = run && (div_cnt_q == CW'(DIV - 1));

   // Next pattern value for the mode currently latched.
   always_comb begin
      pat_nxt = 32'd0;
      dir_nxt = dir_q;
      case (cur_mode_q)
         MODE_COUNT: pat_nxt = pat_q + 32'd1;
         MODE_WALK:  pat_nxt = {pat_q[30:0], pat_q[31]};
         MODE_BOUNCE: begin
            // Endpoints jump straight to their neighbour so each end is lit only once per pass.
            if (!dir_q) begin
               if (pat_q == PAT_TOP) begin
                  pat_nxt = 32'h4000_0000;
                  dir_nxt = 1'b1;
               end else begin
                  pat_nxt = pat_q << 1;
               end
            end else begin
               if (pat_q == PAT_BOT) begin
                  pat_nxt = 32'h0000_0002;
                  dir_nxt = 1'b0;
               end else begin
                  pat_nxt = pat_q >> 1;
               end
            end
         end
         MODE_FILL:  pat_nxt = (pat_q == PAT_ALL) ? 32'd0 : {pat_q[30:0], 1'b1};
         MODE_BLINK: pat_nxt = ~pat_q;
         default:    pat_nxt = 32'd0;
      endcase
   end

   always_comb begin
      div_cnt_d   = div_cnt_q;
      cur_mode_d  = cur_mode_q;
      pat_d       = pat_q;
      dir_d       = dir_q;
      step_tick_d = 1'b0;
      if (mode != cur_mode_q) begin
         // A mode change restarts the animation and the step period, even when frozen.
         cur_mode_d = mode;
         pat_d      = init_pat(mode);
         dir_d      = 1'b0;
         div_cnt_d  = '0;
      end else begin
         if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
         end
         if (tick) begin
            pat_d       = pat_nxt;
            dir_d       = dir_nxt;
            step_tick_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q   <= '0;
         cur_mode_q  <= MODE_OFF;
         pat_q       <= 32'd0;
         dir_q       <= 1'b0;
         step_tick_q <= 1'b0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         cur_mode_q  <= cur_mode_d;
         pat_q       <= pat_d;
         dir_q       <= dir_d;
         step_tick_q <= step_tick_d;
      end
   end

   assign step_tick = step_tick_q;
   assign pmod      = pat_q;
   assign led       = pat_q[31:24];

endmodule

// File: tb/tb_pmod_led_pattern_gen.sv
// Purpose : directed bench for pmod_led_pattern_gen with DIV=4 and a closed-form pattern model.
// Latency : model predicts pattern from step count n since the last (re)start of a mode.
// Backpres: not applicable; every wait on step_tick is bounded by a cycle budget.
module tb_pmod_led_pattern_gen;

   localparam int DIV = 4;

   logic            clk;
   logic            rst;
   logic [2:0]      mode;
   logic            run;
   logic            step_tick;
   logic [3:0][7:0] pmod;
   logic [7:0]      led;

   int tests;
   int fails;

   pmod_led_pattern_gen #(.DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .run       (run),
      .step_tick (step_tick),
      .pmod      (pmod),
      .led       (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Closed-form pattern after n steps in mode m.
   function automatic logic [31:0] model_pat(input int m, input longint n);
      logic [31:0] r;
      int p;
      r = 32'd0;
      case (m)
         1: r = 32'(n);
         2: r = 32'h1 << (n % 32);
         3: begin
            p = int'(n % 62);
            r = (p <= 31) ? (32'h1 << p) : (32'h1 << (62 - p));
         end
         4: begin
            p = int'(n % 33);
            r = (p == 32) ? 32'hFFFF_FFFF : ((32'h1 << p) - 32'h1);
         end
         5: r = (n % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Model state: mode latched, steps since restart, run cycles into the current period.
   bit     m_valid;
   int     m_mode;
   longint m_n;
   int     m_cnt;
   bit     m_tick;

   initial begin
      m_valid = 1'b0;
      m_mode  = 0;
      m_n     = 0;
      m_cnt   = 0;
      m_tick  = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1'b1;
         m_mode  = 0;
         m_n     = 0;
         m_cnt   = 0;
         m_tick  = 1'b0;
      end else if (m_valid) begin
         if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_n    = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
         end else if (run) begin
            m_cnt++;
            if (m_cnt == DIV) begin
               m_cnt  = 0;
               m_n++;
               m_tick = 1'b1;
            end else begin
               m_tick = 1'b0;
            end
         end else begin
            m_tick = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model once reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_pat",  pmod, model_pat(m_mode, m_n));
         check("cyc_led",  {24'd0, led}, {24'd0, model_pat(m_mode, m_n) >> 24});
         check("cyc_tick", {31'd0, step_tick}, {31'd0, m_tick});
      end
   end

   // Wait (from a negedge) until step_tick is seen at a negedge; returns clocks elapsed.
   task automatic wait_pulse(input string name, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 4 * DIV) begin
         @(negedge clk);
         cycles++;
         if (step_tick) seen = 1'b1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s: no step_tick within %0d clocks", name, 4 * DIV);
      end
   endtask

   task automatic wait_steps(input string name, input int n);
      int c;
      for (int i = 0; i < n; i++) wait_pulse(name, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      int c;
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      mode  = 3'd0;
      run   = 1'b0;
      idle(2);
      check("rst_pmod", pmod, 32'h0);
      check("rst_led",  {24'd0, led}, 32'h0);
      check("rst_tick", {31'd0, step_tick}, 32'h0);

      // COUNT
      rst  = 1'b0;
      mode = 3'd1;
      run  = 1'b1;
      idle(1);
      check("count_init", pmod, 32'h0);
      wait_pulse("count_p1", c);
      check("count_p1_lat", c, 32'd4);
      check("count_p1", {24'd0, pmod[0]}, 32'd1);
      wait_pulse("count_p2", c);
      check("count_period", c, 32'd4);
      check("count_p2", {24'd0, pmod[0]}, 32'd2);
      wait_pulse("count_p3", c);
      check("count_p3", {24'd0, pmod[0]}, 32'd3);
      check("count_hi", {pmod[3], pmod[2], pmod[1], led}, 32'h0);

      // WALK
      mode = 3'd2;
      idle(1);
      check("walk_init", pmod, 32'h1);
      wait_steps("walk", 31);
      check("walk_31", pmod, 32'h8000_0000);
      check("walk_31_led", {24'd0, led}, 32'h80);
      wait_steps("walk", 1);
      check("walk_32", pmod, 32'h1);

      // BOUNCE
      mode = 3'd3;
      idle(1);
      wait_steps("bounce", 31);
      check("bounce_31", pmod, 32'h8000_0000);
      wait_steps("bounce", 1);
      check("bounce_32", pmod, 32'h4000_0000);
      wait_steps("bounce", 30);
      check("bounce_62", pmod, 32'h1);
      wait_steps("bounce", 1);
      check("bounce_63", pmod, 32'h2);

      // FILL
      mode = 3'd4;
      idle(1);
      wait_steps("fill", 32);
      check("fill_32", pmod, 32'hFFFF_FFFF);
      check("fill_32_p0", {24'd0, pmod[0]}, 32'hFF);
      check("fill_32_led", {24'd0, led}, 32'hFF);
      wait_steps("fill", 1);
      check("fill_33", pmod, 32'h0);

      // COUNT with run frozen mid-period
      mode = 3'd1;
      idle(1);
      wait_pulse("freeze_pre", c);
      check("freeze_pre", pmod, 32'h1);
      idle(2);
      run = 1'b0;
      idle(20);
      check("freeze_hold", pmod, 32'h1);
      run = 1'b1;
      wait_pulse("freeze_post", c);
      check("freeze_remain", c, 32'd2);
      check("freeze_post", pmod, 32'h2);

      // Mode change on terminal-count cycle beats the step
      idle(3);
      mode = 3'd5;
      idle(1);
      check("mchg_pat", pmod, 32'h0);
      check("mchg_tick", {31'd0, step_tick}, 32'h0);
      wait_pulse("blink_p1", c);
      check("blink_lat", c, 32'd4);
      check("blink_p1", pmod, 32'hFFFF_FFFF);

      // Reset mid-run, then INIT reload via the mode-change path
      idle(1);
      rst = 1'b1;
      idle(1);
      check("mrst_pmod", pmod, 32'h0);
      check("mrst_led",  {24'd0, led}, 32'h0);
      check("mrst_tick", {31'd0, step_tick}, 32'h0);
      rst  = 1'b0;
      mode = 3'd2;
      idle(1);
      check("mrst_init", pmod, 32'h1);
      wait_steps("mrst_walk", 2);
      check("mrst_walk2", pmod, 32'h4);

      // Mode 6 behaves as OFF
      mode = 3'd6;
      idle(1);
      check("mode6_init", pmod, 32'h0);
      wait_steps("mode6", 1);
      check("mode6_step", pmod, 32'h0);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
